// File: rtl/ccu_line_fetch.sv
// rtl/ccu_line_fetch.sv - CCU line fetch engine: reads a cacheline beat by beat and returns it with a done pulse
module ccu_line_fetch #(
    parameter int CCU_ADDR_WIDTH = 32,
    parameter int CCU_LINE_SIZE  = 32,
    parameter int CCU_BEAT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_ccu_en,
    input  logic [CCU_ADDR_WIDTH-1:0]     i_ccu_addr,
    output logic                          o_ccu_done,
    output logic [CCU_LINE_SIZE*8-1:0]    o_ccu_data,
    output logic                          o_mem_rd_en,
    output logic [CCU_ADDR_WIDTH-1:0]     o_mem_addr,
    input  logic                          i_mem_rd_ack,
    input  logic                          i_mem_rd_valid,
    input  logic [CCU_BEAT_WIDTH-1:0]     i_mem_rd_data
);

    localparam int LINE_W     = CCU_LINE_SIZE * 8;
    localparam int NB         = LINE_W / CCU_BEAT_WIDTH;
    localparam int BEAT_CNT_W = $clog2(NB);

    localparam logic [CCU_ADDR_WIDTH-1:0] OFFSET_MASK = CCU_ADDR_WIDTH'(CCU_LINE_SIZE - 1);
    localparam logic [CCU_ADDR_WIDTH-1:0] BEAT_STRIDE = CCU_ADDR_WIDTH'(CCU_BEAT_WIDTH / 8);
    localparam logic [BEAT_CNT_W-1:0]     LAST_BEAT   = BEAT_CNT_W'(NB - 1);
    localparam logic [BEAT_CNT_W-1:0]     BEAT_ONE    = BEAT_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [BEAT_CNT_W-1:0]     beat_q, beat_d;
    logic [CCU_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [LINE_W-1:0]         data_q, data_d;
    logic                      capture;

    // A beat lands either together with its ack or later while waiting.
    always_comb begin
        capture = ((state_q == ST_ISSUE) && i_mem_rd_ack && i_mem_rd_valid) ||
                  ((state_q == ST_WAIT) && i_mem_rd_valid);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ccu_en) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_mem_rd_ack) begin
                    if (!i_mem_rd_valid) begin
                        state_d = ST_WAIT;
                    end else if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (i_mem_rd_valid) begin
                    state_d = (beat_q == LAST_BEAT) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Beats overwrite the line in place, so the previous line stays visible between requests.
    always_comb begin
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        data_d      = data_q;
        if ((state_q == ST_IDLE) && i_ccu_en) begin
            line_addr_d = i_ccu_addr & ~OFFSET_MASK;
            beat_d      = '0;
        end
        if (capture) begin
            data_d[int'(beat_q) * CCU_BEAT_WIDTH +: CCU_BEAT_WIDTH] = i_mem_rd_data;
            beat_d = beat_q + BEAT_ONE;
        end
    end

    always_comb begin
        o_ccu_done  = (state_q == ST_DONE);
        o_mem_rd_en = (state_q == ST_ISSUE);
        o_mem_addr  = line_addr_q + (CCU_ADDR_WIDTH'(beat_q) * BEAT_STRIDE);
        o_ccu_data  = data_q;
    end

endmodule
